// File: rtl/muldiv_seq.sv
// Iterative MUL/IMUL/DIV/IDIV sequencer for the 8088 core.
// All arithmetic is routed through the shared ALU in 3-cycle issue/wait/capture steps.
module muldiv_seq (
    input  logic        CLKx4,
    input  logic        RESETn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        byteWord,
    input  logic [15:0] srcLo,
    input  logic [15:0] srcHi,
    input  logic [15:0] srcOp,
    output logic [15:0] resLo,
    output logic [15:0] resHi,
    output logic        busy,
    output logic        done,
    output logic        divError,
    output logic        mulOverflow,
    output logic [15:0] aluA,
    output logic [15:0] aluB,
    output logic [3:0]  aluOp,
    output logic        aluByteWord,
    output logic        aluCarryIn,
    input  logic [15:0] aluS,
    input  logic        aluCarry
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PRE, S_CHECK, S_LOOP, S_POST, S_DONE} state_t;
    typedef enum logic [1:0] {PH_ISSUE, PH_WAIT, PH_CAPT} phase_t;
    typedef enum logic [1:0] {OP_MUL, OP_IMUL, OP_DIV, OP_IDIV} op_t;

    localparam logic [3:0] ALU_ADD  = 4'b1000;
    localparam logic [3:0] ALU_SUB  = 4'b1101;
    localparam logic [3:0] ALU_NEGA = 4'b0110;
    localparam logic [3:0] ALU_NOTA = 4'b0001;

    state_t      st_q, st_d;
    phase_t      ph_q, ph_d, ph_adv;
    op_t         op_q, op_d;
    logic        bw_q, bw_d;
    logic [15:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  pend_q, pend_d;
    logic        chain_q, chain_d, lonz_q, lonz_d, sq_q, sq_d, sr_q, sr_d;
    logic [15:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
    logic        div_err_q, div_err_d, mul_ovf_q, mul_ovf_d;

    logic [15:0] alu_a, alu_b, mask, ld_mask, s_n, hs, ls;
    logic [3:0]  alu_op, last_idx;
    logic        capt, iter_done;

    function automatic logic msb_of(input logic [15:0] x, input logic bw);
        return bw ? x[15] : x[7];
    endfunction

    always_ff @(posedge CLKx4 or negedge RESETn) begin
        if (!RESETn) begin
            st_q      <= S_IDLE;
            ph_q      <= PH_ISSUE;
            op_q      <= OP_MUL;
            bw_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            pend_q    <= '0;
            chain_q   <= 1'b0;
            lonz_q    <= 1'b0;
            sq_q      <= 1'b0;
            sr_q      <= 1'b0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
            div_err_q <= 1'b0;
            mul_ovf_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            ph_q      <= ph_d;
            op_q      <= op_d;
            bw_q      <= bw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            chain_q   <= chain_d;
            lonz_q    <= lonz_d;
            sq_q      <= sq_d;
            sr_q      <= sr_d;
            res_lo_q  <= res_lo_d;
            res_hi_q  <= res_hi_d;
            div_err_q <= div_err_d;
            mul_ovf_q <= mul_ovf_d;
        end
    end

    always_comb begin
        st_d = st_q;       ph_d = ph_q;         op_d = op_q;       bw_d = bw_q;
        hi_d = hi_q;       lo_d = lo_q;         m_d = m_q;         cnt_d = cnt_q;
        pend_d = pend_q;   chain_d = chain_q;   lonz_d = lonz_q;
        sq_d = sq_q;       sr_d = sr_q;
        res_lo_d = res_lo_q;   res_hi_d = res_hi_q;
        div_err_d = div_err_q; mul_ovf_d = mul_ovf_q;
        alu_a = '0;  alu_b = '0;  alu_op = '0;
        iter_done = 1'b0;
        mask     = bw_q ? 16'hFFFF : 16'h00FF;
        ld_mask  = byteWord ? 16'hFFFF : 16'h00FF;
        last_idx = bw_q ? 4'd15 : 4'd7;
        s_n      = aluS & mask;
        capt     = (ph_q == PH_CAPT);
        ph_adv   = (ph_q == PH_ISSUE) ? PH_WAIT : ((ph_q == PH_WAIT) ? PH_CAPT : PH_ISSUE);
        hs = bw_q ? {hi_q[14:0], lo_q[15]} : {8'h00, hi_q[6:0], lo_q[7]};
        ls = bw_q ? {lo_q[14:0], 1'b0}     : {8'h00, lo_q[6:0], 1'b0};

        case (st_q)
            S_IDLE: if (start) begin
                op_d = op_t'(op);
                bw_d = byteWord;
                m_d  = srcOp & ld_mask;
                cnt_d = '0;
                ph_d = PH_ISSUE;
                div_err_d = 1'b0;
                mul_ovf_d = 1'b0;
                if (!op[1]) begin
                    hi_d = '0;
                    lo_d = srcLo & ld_mask;
                end else if (byteWord) begin
                    hi_d = srcHi;
                    lo_d = srcLo;
                end else begin
                    hi_d = {8'h00, srcLo[15:8]};
                    lo_d = {8'h00, srcLo[7:0]};
                end
                st_d = S_SETUP;
            end
            S_SETUP: begin
                chain_d = 1'b1;
                lonz_d  = 1'b0;
                pend_d  = '0;
                sq_d    = 1'b0;
                sr_d    = 1'b0;
                if (op_q == OP_IMUL) begin
                    pend_d = {msb_of(m_q, bw_q), 1'b0, msb_of(lo_q, bw_q)};
                    sq_d   = msb_of(lo_q, bw_q) ^ msb_of(m_q, bw_q);
                end else if (op_q == OP_IDIV) begin
                    pend_d = {msb_of(m_q, bw_q), msb_of(hi_q, bw_q), msb_of(hi_q, bw_q)};
                    sq_d   = msb_of(hi_q, bw_q) ^ msb_of(m_q, bw_q);
                    sr_d   = msb_of(hi_q, bw_q);
                end
                if (pend_d != '0) st_d = S_PRE;
                else              st_d = op_q[1] ? S_CHECK : S_LOOP;
            end
            // pend bits are serviced lo, hi, m; hi uses NotA when chained to a nonzero lo
            S_PRE, S_POST: begin
                ph_d = ph_adv;
                if (pend_q[0]) begin
                    alu_op = ALU_NEGA;
                    alu_a  = lo_q;
                    if (capt) begin
                        lo_d = s_n;
                        lonz_d = (lo_q != '0);
                        pend_d[0] = 1'b0;
                    end
                end else if (pend_q[1]) begin
                    alu_op = (chain_q && lonz_q) ? ALU_NOTA : ALU_NEGA;
                    alu_a  = hi_q;
                    if (capt) begin
                        hi_d = s_n;
                        pend_d[1] = 1'b0;
                    end
                end else begin
                    alu_op = ALU_NEGA;
                    alu_a  = m_q;
                    if (capt) begin
                        m_d = s_n;
                        pend_d[2] = 1'b0;
                    end
                end
                if (capt && pend_d == '0)
                    st_d = (st_q == S_POST) ? S_DONE : (op_q[1] ? S_CHECK : S_LOOP);
            end
            S_CHECK: begin
                alu_op = ALU_SUB;
                alu_a  = hi_q;
                alu_b  = m_q;
                ph_d   = ph_adv;
                if (capt) begin
                    if (!aluCarry) begin
                        div_err_d = 1'b1;
                        st_d = S_DONE;
                    end else begin
                        st_d = S_LOOP;
                    end
                end
            end
            S_LOOP: begin
                if (!op_q[1] && !lo_q[0]) begin
                    hi_d = bw_q ? {1'b0, hi_q[15:1]} : {9'h000, hi_q[7:1]};
                    lo_d = bw_q ? {hi_q[0], lo_q[15:1]} : {8'h00, hi_q[0], lo_q[7:1]};
                    iter_done = 1'b1;
                end else if (!op_q[1]) begin
                    alu_op = ALU_ADD;
                    alu_a  = hi_q;
                    alu_b  = m_q;
                    ph_d   = ph_adv;
                    if (capt) begin
                        hi_d = bw_q ? {aluCarry, s_n[15:1]} : {8'h00, aluCarry, s_n[7:1]};
                        lo_d = bw_q ? {s_n[0], lo_q[15:1]} : {8'h00, s_n[0], lo_q[7:1]};
                        iter_done = 1'b1;
                    end
                end else begin
                    // shifted partial remainder is presented combinationally; hi/lo move only at capture
                    alu_op = ALU_SUB;
                    alu_a  = hs;
                    alu_b  = m_q;
                    ph_d   = ph_adv;
                    if (capt) begin
                        iter_done = 1'b1;
                        if (msb_of(hi_q, bw_q) || !aluCarry) begin
                            hi_d = s_n;
                            lo_d = ls | 16'h0001;
                        end else begin
                            hi_d = hs;
                            lo_d = ls;
                        end
                    end
                end
            end
            S_DONE:  st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase

        if (iter_done) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == last_idx) begin
                st_d = S_DONE;
                if (op_q == OP_IMUL && sq_q) begin
                    st_d    = S_POST;
                    pend_d  = 3'b011;
                    chain_d = 1'b1;
                end else if (op_q == OP_IDIV) begin
                    if (msb_of(lo_d, bw_q)) begin
                        div_err_d = 1'b1;
                    end else if (sq_q || sr_q) begin
                        st_d    = S_POST;
                        pend_d  = {1'b0, sr_q, sq_q};
                        chain_d = 1'b0;
                    end
                end
            end
        end

        if (st_d == S_DONE && st_q != S_DONE) begin
            if (!div_err_d) begin
                res_hi_d = bw_q ? hi_d : '0;
                res_lo_d = bw_q ? lo_d : {hi_d[7:0], lo_d[7:0]};
            end
            case (op_q)
                OP_MUL:  mul_ovf_d = ((hi_d & mask) != '0);
                OP_IMUL: mul_ovf_d = bw_q ? (hi_d != {16{lo_d[15]}}) : (hi_d[7:0] != {8{lo_d[7]}});
                default: mul_ovf_d = 1'b0;
            endcase
        end
    end

    assign resLo       = res_lo_q;
    assign resHi       = res_hi_q;
    assign divError    = div_err_q;
    assign mulOverflow = mul_ovf_q;
    assign busy        = (st_q != S_IDLE);
    assign done        = (st_q == S_DONE);
    assign aluA        = alu_a;
    assign aluB        = alu_b;
    assign aluOp       = alu_op;
    assign aluByteWord = bw_q;
    assign aluCarryIn  = 1'b0;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq with a behavioural ALU attached to the operand/opcode mux.
module tb_muldiv_seq;
    logic        CLKx4 = 1'b0;
    logic        RESETn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic        byteWord = 1'b0;
    logic [15:0] srcLo = '0, srcHi = '0, srcOp = '0;
    logic [15:0] resLo, resHi, aluA, aluB, aluS;
    logic        busy, done, divError, mulOverflow, aluByteWord, aluCarryIn, aluCarry;
    logic [3:0]  aluOp;

    muldiv_seq dut (
        .CLKx4(CLKx4), .RESETn(RESETn), .start(start), .op(op), .byteWord(byteWord),
        .srcLo(srcLo), .srcHi(srcHi), .srcOp(srcOp), .resLo(resLo), .resHi(resHi),
        .busy(busy), .done(done), .divError(divError), .mulOverflow(mulOverflow),
        .aluA(aluA), .aluB(aluB), .aluOp(aluOp), .aluByteWord(aluByteWord),
        .aluCarryIn(aluCarryIn), .aluS(aluS), .aluCarry(aluCarry)
    );

    always #5 CLKx4 = ~CLKx4;

    // behavioural ALU: width-limited add/sub/neg/not, Sub carry is the borrow
    logic [15:0] am, aa, ab;
    logic [16:0] aw;
    always_comb begin
        am = aluByteWord ? 16'hFFFF : 16'h00FF;
        aa = aluA & am;
        ab = aluB & am;
        aw = '0;
        aluS = '0;
        aluCarry = 1'b0;
        case (aluOp)
            4'b1000: begin
                aw = {1'b0, aa} + {1'b0, ab};
                aluS = aw[15:0] & am;
                aluCarry = aluByteWord ? aw[16] : aw[8];
            end
            4'b1101: begin
                aluS = (aa - ab) & am;
                aluCarry = (aa < ab);
            end
            4'b0110: aluS = (16'h0000 - aa) & am;
            4'b0001: aluS = (~aa) & am;
            default: ;
        endcase
    end

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        err;
        logic        ovf;
        int          lat;
        int          t0;
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge CLKx4) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic pulse_start(input logic [1:0] o, input logic bw,
                               input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] opnd);
        op = o; byteWord = bw; srcLo = lo; srcHi = hi; srcOp = opnd;
        start = 1'b1;
        @(posedge CLKx4);
        #1;
        start = 1'b0;
    endtask

    task automatic issue(input string nm, input logic [1:0] o, input logic bw,
                         input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] opnd,
                         input logic [15:0] elo, input logic [15:0] ehi,
                         input logic eerr, input logic eovf, input int lat);
        exp_t e;
        pulse_start(o, bw, lo, hi, opnd);
        e.lo = elo; e.hi = ehi; e.err = eerr; e.ovf = eovf;
        e.lat = lat; e.t0 = cyc; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 400) begin
            @(posedge CLKx4);
            #1;
            k++;
        end
        if (k >= 400) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    // monitor: every done pulse is matched against the oldest expected response
    initial forever begin
        @(negedge CLKx4);
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 required no done");
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.nm, "_resLo"}, {16'h0, resLo}, {16'h0, mon_e.lo});
                chk({mon_e.nm, "_resHi"}, {16'h0, resHi}, {16'h0, mon_e.hi});
                chk({mon_e.nm, "_divError"}, {31'h0, divError}, {31'h0, mon_e.err});
                chk({mon_e.nm, "_mulOverflow"}, {31'h0, mulOverflow}, {31'h0, mon_e.ovf});
                chk({mon_e.nm, "_latency"}, cyc - mon_e.t0, mon_e.lat);
            end
            @(negedge CLKx4);
            chk("done_pulse_busy_done", {30'h0, busy, done}, 32'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("reset_outputs", {resLo, resHi}, 32'h0);
        chk("reset_status", {28'h0, busy, done, divError, mulOverflow}, 32'h0);
        chk("reset_alu", {aluA, aluB}, 32'h0);
        chk("reset_aluop", {27'h0, aluOp, aluByteWord}, 32'h0);
        @(negedge CLKx4);
        RESETn = 1'b1;
        @(posedge CLKx4);
        #1;

        issue("mul_b_3x5", 2'b00, 1'b0, 16'h0003, 16'h0, 16'h0005, 16'h000F, 16'h0000, 1'b0, 1'b0, 13);
        drain();

        issue("mul_w_ffff", 2'b00, 1'b1, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b1, 49);
        @(negedge CLKx4);
        chk("mul_w_setup_aluop", {28'h0, aluOp}, 32'h0);
        for (int k = 1; k <= 48; k++) begin
            @(negedge CLKx4);
            chk("mul_w_aluop_add", {28'h0, aluOp}, 32'h8);
            if (k == 1) chk("mul_w_step1_ab", {aluA, aluB}, 32'h0000FFFF);
            if (k == 4) chk("mul_w_step2_a", {16'h0, aluA}, 32'h00007FFF);
            if (k == 6) chk("mul_w_alubw", {31'h0, aluByteWord}, 32'h1);
        end
        drain();

        issue("div_w_10000_3", 2'b10, 1'b1, 16'h0000, 16'h0001, 16'h0003, 16'h5555, 16'h0001, 1'b0, 1'b0, 52);
        drain();
        issue("div_b_ovf", 2'b10, 1'b0, 16'h0400, 16'h0, 16'h0004, 16'h5555, 16'h0001, 1'b1, 1'b0, 4);
        drain();
        issue("div_b_zero", 2'b10, 1'b0, 16'h0400, 16'h0, 16'h0000, 16'h5555, 16'h0001, 1'b1, 1'b0, 4);
        drain();
        issue("idiv_b_m7_2", 2'b11, 1'b0, 16'hFFF9, 16'h0, 16'h0002, 16'hFFFD, 16'h0000, 1'b0, 1'b0, 40);
        drain();
        issue("imul_b_m1x2", 2'b01, 1'b0, 16'h00FF, 16'h0, 16'h0002, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 20);
        drain();
        issue("idiv_b_m128", 2'b11, 1'b0, 16'hFF80, 16'h0, 16'h0001, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 34);
        drain();
        issue("imul_w_min_m1", 2'b01, 1'b1, 16'h8000, 16'h0, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 25);
        drain();
        issue("idiv_w_m7_2", 2'b11, 1'b1, 16'hFFF9, 16'hFFFF, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 64);
        drain();
        issue("mul_b_zero", 2'b00, 1'b0, 16'hAB00, 16'h0, 16'h0055, 16'h0000, 16'h0000, 1'b0, 1'b0, 9);
        drain();

        // abort a word divide at cycle 10
        pulse_start(2'b10, 1'b1, 16'h0000, 16'h0001, 16'h0003);
        repeat (10) @(posedge CLKx4);
        #1;
        RESETn = 1'b0;
        #1;
        chk("abort_results", {resLo, resHi}, 32'h0);
        chk("abort_status", {28'h0, busy, done, divError, mulOverflow}, 32'h0);
        chk("abort_alu", {aluA, aluB}, 32'h0);
        chk("abort_aluop", {27'h0, aluOp, aluByteWord}, 32'h0);
        @(negedge CLKx4);
        RESETn = 1'b1;
        @(posedge CLKx4);
        #1;

        issue("mul_b_12x34", 2'b00, 1'b0, 16'h0012, 16'h0, 16'h0034, 16'h03A8, 16'h0000, 1'b0, 1'b1, 13);
        repeat (3) @(posedge CLKx4);
        #1;
        pulse_start(2'b00, 1'b0, 16'h00FF, 16'h0, 16'h00FF);
        drain();
        repeat (40) @(posedge CLKx4);
        #1;
        chk("idle_after_ignored_start", {31'h0, busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the 8088 core. It executes MUL, IMUL, DIV and IDIV (byte and word) by driving the shared `alu` instance step by step. Operand magnitudes, shift registers and control stay local; every add, subtract and negate goes through the ALU. It sits between the execution microsequencer (start/done handshake) and the ALU operand/opcode mux.

## Interface
Parameters: none.

Ports:
- `CLKx4`, in, 1: core clock.
- `RESETn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: command strobe. Sampled only while `busy`=0.
- `op`, in, 2: 00 MUL, 01 IMUL, 10 DIV, 11 IDIV.
- `byteWord`, in, 1: 1 = word (n=16), 0 = byte (n=8).
- `srcLo`, in, 16: AX.
- `srcHi`, in, 16: DX. Used only by word DIV/IDIV.
- `srcOp`, in, 16: explicit operand (multiplicand or divisor). Uses low n bits.
- `resLo`, out, 16: result AX.
- `resHi`, out, 16: result DX.
- `busy`, out, 1: command in progress.
- `done`, out, 1: one-cycle completion pulse.
- `divError`, out, 1: divide overflow. Valid with `done`; held until the next start.
- `mulOverflow`, out, 1: CF/OF value for MUL/IMUL. Valid with `done`.
- `aluA`, out, 16: ALU operand A.
- `aluB`, out, 16: ALU operand B.
- `aluOp`, out, 4: ALU opcode.
- `aluByteWord`, out, 1: ALU width select. Equals the latched `byteWord`.
- `aluCarryIn`, out, 1: constant 0.
- `aluS`, in, 16: ALU result.
- `aluCarry`, in, 1: ALU F_Carry. For Sub this is the borrow.

## Operation
- **ALU opcodes used:** Add 1000, Sub 1101, NegA 0110, NotA 0001. Only the low n bits of `aluS` are used.
- **ALU step:** 3 cycles, states ISSUE, WAIT, CAPTURE.
  - `aluA`, `aluB` and `aluOp` are held constant for all 3 cycles.
  - `aluS` and `aluCarry` are sampled in CAPTURE.
  - Outside steps, `aluOp`=0000 and `aluA`=`aluB`=0.
- **Operand load:** the `start` edge latches `op`, `byteWord` and operands.
  - MUL/IMUL: hi=0, lo=`srcLo`[n-1:0], m=`srcOp`[n-1:0].
  - DIV/IDIV, word: {hi,lo}={`srcHi`,`srcLo`}.
  - DIV/IDIV, byte: hi=`srcLo`[15:8], lo=`srcLo`[7:0].
  - Divisor d=`srcOp`[n-1:0].
- **PRE (IMUL/IDIV only):**
  - Each negative operand is replaced by its magnitude with NegA, one step each.
  - A negative 2n-bit dividend takes two steps: lo=NegA(lo), then hi=NegA(hi) if the original lo==0, else NotA(hi).
  - Signs are recorded: sP = sign(lo_in) XOR sign(m). sQ = sign(dividend) XOR sign(d). sR = sign(dividend).
- **MUL loop:** n iterations.
  - If lo[0]=1: one Add step (hi+m); in CAPTURE, {hi,lo} = {aluCarry, S, lo} >> 1.
  - If lo[0]=0: a single cycle, {hi,lo} = {0, hi, lo} >> 1.
- **DIV CHECK:** one Sub step (hi−d).
  - aluCarry=0 → divError=1, go to DONE. This also covers d=0.
- **DIV loop:** n iterations.
  - Shift {hi,lo} left by 1, keeping the bit shifted out (msb).
  - Sub step (hi−d).
  - In CAPTURE: if msb=1 or aluCarry=0, then hi=S and lo[0]=1; else lo[0]=0.
  - Result: quotient=lo, remainder=hi.
- **POST:**
  - IMUL with sP=1: negate {hi,lo} with the two-step method above.
  - IDIV: magnitude quotient bit n-1 set → divError=1, skip negation. This intentionally rejects quotient −2^(n-1), matching 8088 behaviour.
  - Otherwise, IDIV negates q if sQ and negates r if sR, one step each.
- **Results:**
  - Word: `resHi`=hi, `resLo`=lo.
  - Byte MUL: `resLo`={hi,lo}.
  - Byte DIV: `resLo`={rem,quot}.
  - Byte: `resHi`=0.
  - On divError, `resLo`/`resHi` keep their prior values.
- **mulOverflow:**
  - MUL: hi≠0.
  - IMUL: hi ≠ n copies of lo[n-1].
  - DIV/IDIV: 0.
- **State machine:** IDLE → (PRE) → CHECK (div only) → LOOP → (POST) → DONE → IDLE.

## Timing
- **Reset:** all outputs 0; state IDLE.
  - Asserting RESETn mid-operation aborts immediately.
  - No `done` is produced for the aborted command.
- **Start:** the `start` edge in IDLE sets `busy`=1. That edge is cycle 0.
- **done:** high for exactly the DONE cycle. `busy` is high through DONE and low the following cycle.
  - A new `start` is accepted in that following cycle.
  - `start` while `busy`=1 is ignored.
- **Unsigned latency (cycle index of `done`):**
  - MUL: 1 + 3p + (n−p), where p = popcount(multiplier).
  - DIV: 4 + 3n, i.e. 28 (byte) or 52 (word).
  - DIV error: 4.
- **Signed latency:** add 3 cycles per PRE/POST ALU step.
- **Outputs:** `resLo`, `resHi`, `divError` and `mulOverflow` update on the edge entering DONE and are stable until the next start.

## Test plan
- MUL byte, `srcLo`=0x0003, `srcOp`=0x0005 → `resLo`=0x000F, `resHi`=0, `mulOverflow`=0, `done` at cycle 13.
- MUL word, 0xFFFF×0xFFFF → `resHi`=0xFFFE, `resLo`=0x0001, `mulOverflow`=1, `done` at cycle 49. Check `aluOp`=1000 held for 3 cycles per step.
- DIV word, `srcHi`=0x0001, `srcLo`=0x0000, `srcOp`=0x0003 → `resLo`=0x5555, `resHi`=0x0001, `divError`=0, `done` at cycle 52.
- DIV byte, `srcLo`=0x0400, `srcOp`=0x04 → `divError`=1 at cycle 4, results unchanged. Repeat with `srcOp`=0 → same.
- IDIV byte, `srcLo`=0xFFF9, `srcOp`=0x02 → `resLo`=0xFFFD. IMUL byte, 0xFF×0x02 → `resLo`=0xFFFE, `mulOverflow`=0. IDIV byte, 0xFF80 / 0x01 → `divError`=1.
- Pulse RESETn low at cycle 10 of a word DIV → all outputs 0, no `done`. Then `start` while `busy` is ignored and the first command completes with correct results.
